game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Parametrised game-state controller: owns gamemode FSM, player vertical
//  position and player/obstacle collision. Sits between button/switch inputs,
//  obstacle generator and VGA renderer. Generalises to N_OBS obstacles and
//  configurable geometry, and adds frame-tick movement, clamping, collision
//  game-over and synchronised button edges.
// PARAMETERS
//  N_OBS        10   obstacle slots
//  X_W          10   x-coordinate width
//  Y_W          9    y-coordinate width
//  UPPER_BOUND  0    top playfield row
//  LOWER_BOUND  480  bottom playfield row (exclusive)
//  PLAYER_SIZE  40   player square side, pixels
//  PLAYER_X     100  fixed player left column
//  START_Y      220  player_y after reset / restart
//  STEP         2    pixels moved per tick
//  SCORE_W      16   score width (SCORE_EN only)
// PORTS
//  clk         in   1                 system clock
//  rst         in   1                 async active-high reset
//  tick        in   1                 frame tick, 1-cycle pulse
//  sw          in   1                 direction invert (1 = invert)
//  btn         in   3                 async buttons: [0] dir toggle, [1] start/pause, [2] restart
//  obstacle_x  in   N_OBS*2*X_W       slot i at [i*2*X_W +: 2*X_W] = {left,right}
//  obstacle_y  in   N_OBS*2*Y_W       slot i at [i*2*Y_W +: 2*Y_W] = {top,bottom}
//  gamemode    out  2                 00 INIT, 01 PLAY, 10 PAUSE, 11 OVER
//  player_y    out  Y_W               player top row
//  crash       out  1                 1-cycle pulse on PLAY->OVER
//  score       out  SCORE_W           ticks survived (SCORE_EN only)
// BEHAVIOUR
//  - Reset (async): gamemode=00, player_y=START_Y, crash=0, dir=0, sync flops=0, score=0.
//  - btn: 2-flop sync + edge reg per bit; press pulse 3 clk after btn goes high.
//    Held button = one press. FSM acts on cycle of pulse.
//  - FSM, priority high->low: btn2 press > collision > btn1 press.
//    any --btn2--> INIT (player_y=START_Y, dir=0); INIT --btn1--> PLAY;
//    PLAY --hit_q--> OVER (crash=1 one cycle); PLAY --btn1--> PAUSE;
//    PAUSE --btn1--> PLAY; OVER leaves only via btn2.
//  - btn0 press toggles dir in PLAY only; ignored elsewhere.
//  - Movement: PLAY & tick only. up = dir ^ sw. next = player_y -/+ STEP,
//    computed in Y_W+2 signed bits, clamped to [UPPER_BOUND,
//    LOWER_BOUND-PLAYER_SIZE]. No wrap. Held in INIT/PAUSE/OVER.
//  - Slot active iff left<right and top<bottom; inactive slots never hit.
//  - Hit when an active slot satisfies all of: PLAYER_X<right,
//    PLAYER_X+PLAYER_SIZE>left, player_y<bottom, player_y+PLAYER_SIZE>top.
//    Edges that only touch = no hit.
//  - OR of all slots registered into hit_q each cycle. gamemode=11 two clk
//    after the offending player_y/obstacle value appears. hit_q in INIT/PAUSE ignored.
//  - Collision and tick same cycle in PLAY: OVER, player_y not updated.
// CONFIGURATION
//  GAME_CTRL_SCORE_EN defined: score port present. +1 per tick in PLAY,
//    saturates at all-ones, held in PAUSE/OVER, cleared on entering INIT.
//  Not defined: no score port, no counter logic; all else identical.
// TESTING
//  1 rst pulse -> gamemode=00, player_y=220, crash=0.
//  2 btn1 press -> gamemode=01 3 clk later; sw=0, dir=0, 10 ticks -> player_y=240.
//  3 PLAY, 200 ticks down -> player_y=440 held; sw=1, 300 ticks -> player_y=0, no wrap.
//  4 slot 3 = x{90,130} y{200,260}, player_y=220 -> crash pulse 1 clk,
//    gamemode=11 within 2 clk; btn1 ignored; btn2 -> 00, player_y=220.
//  5 btn1 in PLAY -> 10; 5 ticks, player_y unchanged; btn1 -> 01.
//    Slot {100,100} (inactive) over player -> no crash.
//  6 btn1+btn2 same cycle in PAUSE -> 00; rst mid-PLAY -> all outputs reset at once.
//    SCORE_EN: 7 ticks PLAY -> score=7; btn2 -> 0.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: game-state controller for the obstacle game.
// Owns the gamemode FSM, the player's vertical position and the
// player/obstacle collision check. Button inputs are asynchronous and are
// synchronised and edge-detected here.
// Optional feature: define GAME_CTRL_SCORE_EN to add the score port/counter.
module game_ctrl #(
  parameter int N_OBS       = 10,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int UPPER_BOUND = 0,
  parameter int LOWER_BOUND = 480,
  parameter int PLAYER_SIZE = 40,
  parameter int PLAYER_X    = 100,
  parameter int START_Y     = 220,
  parameter int STEP        = 2
`ifdef GAME_CTRL_SCORE_EN
  , parameter int SCORE_W   = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   sw,
  input  logic [2:0]             btn,
  input  logic [N_OBS*2*X_W-1:0] obstacle_x,
  input  logic [N_OBS*2*Y_W-1:0] obstacle_y,
  output logic [1:0]             gamemode,
  output logic [Y_W-1:0]         player_y,
  output logic                   crash
`ifdef GAME_CTRL_SCORE_EN
  , output logic [SCORE_W-1:0]   score
`endif
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Fixed geometry, pre-sized so every comparison is width-matched.
  localparam int PX_R_I = PLAYER_X + PLAYER_SIZE;
  localparam int LB_I   = LOWER_BOUND - PLAYER_SIZE;
  localparam logic [X_W:0]          PX_L    = PLAYER_X[X_W:0];
  localparam logic [X_W:0]          PX_R    = PX_R_I[X_W:0];
  localparam logic [Y_W:0]          PSIZE_Y = PLAYER_SIZE[Y_W:0];
  localparam logic [Y_W-1:0]        START_V = START_Y[Y_W-1:0];
  localparam logic signed [Y_W+1:0] STEP_S  = STEP[Y_W+1:0];
  localparam logic signed [Y_W+1:0] UB_S    = UPPER_BOUND[Y_W+1:0];
  localparam logic signed [Y_W+1:0] LB_S    = LB_I[Y_W+1:0];

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_sync1, r_sync2, r_btn_prev;
  logic [2:0]     w_press;
  logic           w_hit, r_hit_q;
  logic           w_restart, w_crash_set, w_move, w_toggle;
  logic [Y_W-1:0] r_player_y;
  logic           r_dir, r_crash;

  // One step of movement, done in signed arithmetic wide enough that an
  // underflow past row 0 stays negative and is clamped instead of wrapping.
  function automatic logic [Y_W-1:0] step_clamp(input logic [Y_W-1:0] y,
                                                 input logic up);
    logic signed [Y_W+1:0] v;
    v = $signed({2'b00, y});
    if (up) v = v - STEP_S;
    else    v = v + STEP_S;
    if (v < UB_S)      v = UB_S;
    else if (v > LB_S) v = LB_S;
    return v[Y_W-1:0];
  endfunction

  // Strict overlap test for one slot; a degenerate (empty) slot never hits
  // and rectangles that merely share an edge do not count.
  function automatic logic slot_hit(input logic [X_W-1:0] l, input logic [X_W-1:0] r,
                                    input logic [Y_W-1:0] t, input logic [Y_W-1:0] b,
                                    input logic [Y_W-1:0] py);
    logic [Y_W:0] py_bot;
    py_bot = {1'b0, py} + PSIZE_Y;
    return (l < r) && (t < b) &&
           (PX_L < {1'b0, r}) && (PX_R > {1'b0, l}) &&
           (py < b) && (py_bot > {1'b0, t});
  endfunction

  // Two-flop synchroniser plus previous-value register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_btn_prev <= '0;
    end else begin
      r_sync1    <= btn;
      r_sync2    <= r_sync1;
      r_btn_prev <= r_sync2;
    end
  end

  assign w_press = r_sync2 & ~r_btn_prev;

  // OR of the overlap test across every obstacle slot.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      w_hit = w_hit | slot_hit(obstacle_x[i*2*X_W + X_W +: X_W],
                               obstacle_x[i*2*X_W +: X_W],
                               obstacle_y[i*2*Y_W + Y_W +: Y_W],
                               obstacle_y[i*2*Y_W +: Y_W],
                               r_player_y);
    end
  end

  // Registered collision flag; the FSM only looks at this one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hit_q <= 1'b0;
    else     r_hit_q <= w_hit;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  // Next state and control strobes: restart beats collision beats start/pause.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_crash_set = 1'b0;
    if (w_press[2]) begin
      w_state_nxt = ST_INIT;
      w_restart   = 1'b1;
    end else if (r_state == ST_PLAY && r_hit_q) begin
      w_state_nxt = ST_OVER;
      w_crash_set = 1'b1;
    end else if (w_press[1]) begin
      case (r_state)
        ST_INIT:  w_state_nxt = ST_PLAY;
        ST_PLAY:  w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_PLAY;
        default:  w_state_nxt = r_state;
      endcase
    end
    w_move   = (r_state == ST_PLAY) && tick && !r_hit_q && !w_press[2];
    w_toggle = (r_state == ST_PLAY) && w_press[0] && !w_press[2];
  end

  // Player position, direction and crash pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_player_y <= START_V;
      r_dir      <= 1'b0;
      r_crash    <= 1'b0;
    end else begin
      r_crash <= w_crash_set;
      if (w_restart) begin
        r_player_y <= START_V;
        r_dir      <= 1'b0;
      end else begin
        if (w_move)   r_player_y <= step_clamp(r_player_y, r_dir ^ sw);
        if (w_toggle) r_dir      <= ~r_dir;
      end
    end
  end

`ifdef GAME_CTRL_SCORE_EN
  logic [SCORE_W-1:0] r_score;

  // Ticks survived in PLAY, saturating; cleared on restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_score <= '0;
    else if (w_restart)                  r_score <= '0;
    else if (w_move && (r_score != '1))  r_score <= r_score + 1'b1;
  end

  assign score = r_score;
`endif

  assign gamemode = r_state;
  assign player_y = r_player_y;
  assign crash    = r_crash;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed bench for game_ctrl with a cycle-level reference
// model of the game rules and literal checkpoints along the way.
module tb_game_ctrl;
  localparam int N_OBS = 10;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  logic                   clk = 1'b0;
  logic                   rst, tick, sw;
  logic [2:0]             btn;
  logic [N_OBS*2*X_W-1:0] obstacle_x;
  logic [N_OBS*2*Y_W-1:0] obstacle_y;
  logic [1:0]             gamemode;
  logic [Y_W-1:0]         player_y;
  logic                   crash;
`ifdef GAME_CTRL_SCORE_EN
  logic [15:0]            score;
`endif

  game_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .sw(sw), .btn(btn),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .gamemode(gamemode), .player_y(player_y), .crash(crash)
`ifdef GAME_CTRL_SCORE_EN
    , .score(score)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Obstacle rectangles as the model sees them.
  int obl[N_OBS], obr[N_OBS], obt[N_OBS], obb[N_OBS];

  task automatic set_slot(input int i, input int l, input int r, input int t, input int b);
    logic [X_W-1:0] lx, rx;
    logic [Y_W-1:0] ty, by;
    obl[i] = l; obr[i] = r; obt[i] = t; obb[i] = b;
    lx = l[X_W-1:0]; rx = r[X_W-1:0];
    ty = t[Y_W-1:0]; by = b[Y_W-1:0];
    obstacle_x[i*2*X_W +: 2*X_W] = {lx, rx};
    obstacle_y[i*2*Y_W +: 2*Y_W] = {ty, by};
  endtask

  function automatic int collide(input int y);
    for (int i = 0; i < N_OBS; i++)
      if (obl[i] < obr[i] && obt[i] < obb[i] && 100 < obr[i] && 140 > obl[i] &&
          y < obb[i] && y + 40 > obt[i]) return 1;
    return 0;
  endfunction

  // Reference model: mode 0 INIT, 1 PLAY, 2 PAUSE, 3 OVER.
  int m_mode, m_y, m_dir, m_crash, m_score, m_hitq;
  bit [2:0] s1, s2, s3;

  always @(posedge clk or posedge rst) begin : model
    bit [2:0] pr;
    int nh, om, ny;
    if (rst) begin
      m_mode = 0; m_y = 220; m_dir = 0; m_crash = 0; m_score = 0; m_hitq = 0;
      s1 = '0; s2 = '0; s3 = '0;
    end else begin
      pr = s2 & ~s3;
      s3 = s2; s2 = s1; s1 = btn;
      nh = collide(m_y);
      om = m_mode;
      m_crash = 0;
      if (pr[2]) begin
        m_mode = 0; m_y = 220; m_dir = 0; m_score = 0;
      end else begin
        if (om == 1 && m_hitq != 0) begin
          m_mode = 3; m_crash = 1;
        end else if (pr[1]) begin
          if (om == 0)      m_mode = 1;
          else if (om == 1) m_mode = 2;
          else if (om == 2) m_mode = 1;
        end
        if (om == 1 && tick && m_hitq == 0) begin
          ny = ((m_dir != 0) ^ sw) ? m_y - 2 : m_y + 2;
          if (ny < 0)   ny = 0;
          if (ny > 440) ny = 440;
          m_y = ny;
          if (m_score < 65535) m_score++;
        end
        if (om == 1 && pr[0]) m_dir = 1 - m_dir;
      end
      m_hitq = nh;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst && chk_on) begin
      chk("mode_vs_model", int'(gamemode), m_mode);
      chk("y_vs_model", int'(player_y), m_y);
      chk("crash_vs_model", int'(crash), m_crash);
`ifdef GAME_CTRL_SCORE_EN
      chk("score_vs_model", int'(score), m_score);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    cyc(1);
    btn[b] = 1'b0;
    cyc(3);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick = 1'b0; sw = 1'b0; btn = '0;
    obstacle_x = '0; obstacle_y = '0;
    for (int i = 0; i < N_OBS; i++) begin
      obl[i] = 0; obr[i] = 0; obt[i] = 0; obb[i] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("reset_mode", int'(gamemode), 0);
    chk("reset_y", int'(player_y), 220);
    chk("reset_crash", int'(crash), 0);
    rst = 1'b0;
    chk_on = 1'b1;
    cyc(2);

    // Start: three clocks of latency, held button counts once.
    btn[1] = 1'b1;
    cyc(2);
    chk("start_not_yet", int'(gamemode), 0);
    cyc(1);
    chk("start_3clk", int'(gamemode), 1);
    cyc(4);
    btn[1] = 1'b0;
    cyc(3);
    chk("held_once", int'(gamemode), 1);
    ticks(10);
    chk("ten_ticks_down", int'(player_y), 240);

    // Clamping at both ends.
    ticks(200);
    chk("clamp_bottom", int'(player_y), 440);
    sw = 1'b1;
    ticks(300);
    chk("clamp_top", int'(player_y), 0);
    sw = 1'b0;

    // Restart, then collision handling.
    press(2);
    chk("restart_mode", int'(gamemode), 0);
    chk("restart_y", int'(player_y), 220);
    press(1);
    chk("replay_mode", int'(gamemode), 1);
    ticks(5);
    chk("y_230", int'(player_y), 230);
    set_slot(0, 90, 130, 190, 230);
    set_slot(1, 60, 100, 200, 260);
    cyc(4);
    chk("touch_no_hit", int'(gamemode), 1);
    chk("touch_no_crash", int'(crash), 0);
    set_slot(0, 0, 0, 0, 0);
    set_slot(1, 0, 0, 0, 0);
    set_slot(3, 90, 130, 200, 260);
    cyc(1);
    chk("hit_1clk_mode", int'(gamemode), 1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("hit_2clk_mode", int'(gamemode), 3);
    chk("hit_crash", int'(crash), 1);
    chk("hit_tick_y_held", int'(player_y), 230);
    cyc(1);
    chk("crash_one_cycle", int'(crash), 0);
    set_slot(3, 0, 0, 0, 0);
    press(1);
    chk("over_ignores_btn1", int'(gamemode), 3);
    press(2);
    chk("over_restart_mode", int'(gamemode), 0);
    chk("over_restart_y", int'(player_y), 220);

    // Pause/resume, inactive slot, direction toggle.
    press(1);
    ticks(3);
    chk("y_226", int'(player_y), 226);
    press(1);
    chk("pause_mode", int'(gamemode), 2);
    ticks(5);
    chk("pause_y_held", int'(player_y), 226);
    press(1);
    chk("resume_mode", int'(gamemode), 1);
    set_slot(2, 100, 100, 200, 260);
    cyc(4);
    chk("inactive_no_hit", int'(gamemode), 1);
    set_slot(2, 0, 0, 0, 0);
    press(0);
    ticks(1);
    chk("toggle_up", int'(player_y), 224);
    press(1);
    press(0);
    press(1);
    ticks(1);
    chk("toggle_ignored_in_pause", int'(player_y), 222);

    // Restart wins over start/pause in the same cycle.
    press(1);
    chk("pause_again", int'(gamemode), 2);
    btn = 3'b110;
    cyc(1);
    btn = '0;
    cyc(3);
    chk("btn12_to_init", int'(gamemode), 0);
    chk("btn12_y", int'(player_y), 220);
    press(1);
    ticks(7);
    chk("y_234", int'(player_y), 234);
`ifdef GAME_CTRL_SCORE_EN
    chk("score_7", int'(score), 7);
`endif

    // Asynchronous reset mid-play.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mode", int'(gamemode), 0);
    chk("async_rst_y", int'(player_y), 220);
    chk("async_rst_crash", int'(crash), 0);
`ifdef GAME_CTRL_SCORE_EN
    chk("async_rst_score", int'(score), 0);
`endif
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("after_rst_mode", int'(gamemode), 0);
`ifdef GAME_CTRL_SCORE_EN
    press(1);
    ticks(3);
    chk("score_3", int'(score), 3);
    press(2);
    chk("score_cleared", int'(score), 0);
`endif
    cyc(2);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
